// File: rtl/nts_api_pkg.sv
// nts_api_pkg: shared types and constants for the NTS external API bus
package nts_api_pkg;

    localparam int API_ADDR_W = 12;
    localparam int API_DATA_W = 32;

    // Decoder windows; space outside these reads back as 0
    localparam logic [API_ADDR_W-1:0] ENGINE_BASE = 12'h000;
    localparam logic [API_ADDR_W-1:0] ENGINE_STOP = 12'h0FF;
    localparam logic [API_ADDR_W-1:0] CLOCK_BASE  = 12'h100;
    localparam logic [API_ADDR_W-1:0] CLOCK_STOP  = 12'h1FF;
    localparam logic [API_ADDR_W-1:0] COOKIE_BASE = 12'h200;
    localparam logic [API_ADDR_W-1:0] COOKIE_STOP = 12'h2FF;
    localparam logic [API_ADDR_W-1:0] KEYMEM_BASE = 12'h300;
    localparam logic [API_ADDR_W-1:0] KEYMEM_STOP = 12'h7FF;
    localparam logic [API_ADDR_W-1:0] DEBUG_BASE  = 12'hF00;
    localparam logic [API_ADDR_W-1:0] DEBUG_STOP  = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_BEAT,
        ST_RD_HOLD,
        ST_RD_RESP
    } state_t;

endpackage

// File: rtl/nts_api_initiator.sv
// nts_api_initiator: turns host read/write burst commands into NTS API bus cycles
module nts_api_initiator
    import nts_api_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [11:0] i_cmd_address,
    input  logic [7:0]  i_cmd_length,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [31:0] i_wr_data,
    output logic        o_rd_valid,
    input  logic        i_rd_ready,
    output logic [31:0] o_rd_data,
    output logic        o_rd_last,
    output logic        o_busy,
    output logic        o_api_cs,
    output logic        o_api_we,
    output logic [11:0] o_api_address,
    output logic [31:0] o_api_write_data,
    input  logic [31:0] i_api_read_data
);

    localparam logic [3:0] HOLD_INIT = 4'(READ_WAIT);

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  rem_q, rem_d;
    logic [3:0]  hold_q, hold_d;
    logic        cs_q, cs_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_last_q, rd_last_d;
    logic        busy_q, busy_d;

    // State, datapath and registered outputs; reset clears everything and abandons any burst
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            hold_q     <= hold_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state: one beat is a wait/beat pair for writes, a hold/response pair for reads
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_cmd_valid) state_d = i_cmd_we ? ST_WR_WAIT : ST_RD_HOLD;
            ST_WR_WAIT: if (i_wr_valid) state_d = ST_WR_BEAT;
            ST_WR_BEAT: state_d = (rem_q == '0) ? ST_IDLE : ST_WR_WAIT;
            ST_RD_HOLD: if (hold_q == '0) state_d = ST_RD_RESP;
            ST_RD_RESP: if (i_rd_ready) state_d = rd_last_q ? ST_IDLE : ST_RD_HOLD;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs and counters; address advances only between beats so the bus always shows addr
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        cs_d       = cs_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        busy_d     = state_d != ST_IDLE;
        case (state_q)
            ST_IDLE: if (i_cmd_valid) begin
                addr_d = i_cmd_address;
                rem_d  = i_cmd_length;
                hold_d = HOLD_INIT;
                cs_d   = !i_cmd_we;
                we_d   = 1'b0;
            end
            ST_WR_WAIT: if (i_wr_valid) begin
                wdata_d = i_wr_data;
                cs_d    = 1'b1;
                we_d    = 1'b1;
            end
            ST_WR_BEAT: begin
                cs_d = 1'b0;
                we_d = 1'b0;
                if (rem_q != '0) begin
                    addr_d = addr_q + 12'd1;
                    rem_d  = rem_q - 8'd1;
                end
            end
            ST_RD_HOLD: begin
                if (hold_q == '0) begin
                    rd_data_d  = i_api_read_data;
                    rd_valid_d = 1'b1;
                    rd_last_d  = rem_q == '0;
                    cs_d       = 1'b0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            ST_RD_RESP: if (i_rd_ready) begin
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
                if (!rd_last_q) begin
                    addr_d = addr_q + 12'd1;
                    rem_d  = rem_q - 8'd1;
                    hold_d = HOLD_INIT;
                    cs_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_cmd_ready      = state_q == ST_IDLE;
    assign o_wr_ready       = state_q == ST_WR_WAIT;
    assign o_busy           = busy_q;
    assign o_api_cs         = cs_q;
    assign o_api_we         = we_q;
    assign o_api_address    = addr_q;
    assign o_api_write_data = wdata_q;
    assign o_rd_valid       = rd_valid_q;
    assign o_rd_data        = rd_data_q;
    assign o_rd_last        = rd_last_q;

endmodule

// File: tb/tb_nts_api_initiator.sv
// tb_nts_api_initiator: directed bench with a transaction-level model and per-cycle checker
module tb_nts_api_initiator;

    localparam int RW = 1;

    typedef struct packed {logic [11:0] a; logic [31:0] d;} wr_t;
    typedef struct packed {logic [31:0] d; logic l;} rd_t;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b1, rd_last, busy;
    logic [31:0] rd_data;
    logic        api_cs, api_we;
    logic [11:0] api_addr;
    logic [31:0] api_wdata, api_rdata;

    always #5 clk = ~clk;

    // Memory model: each word reads as its address xor a fixed pattern, junk when deselected
    assign api_rdata = api_cs ? ({20'h0, api_addr} ^ 32'hA5A5A5A5) : 32'h0BAD0BAD;

    nts_api_initiator #(.READ_WAIT(RW)) dut (
        .i_clk(clk), .i_areset_n(areset_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_address(cmd_addr), .i_cmd_length(cmd_len),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_busy(busy), .o_api_cs(api_cs), .o_api_we(api_we), .o_api_address(api_addr),
        .o_api_write_data(api_wdata), .i_api_read_data(api_rdata)
    );

    int          n_cmp = 0, n_err = 0;
    wr_t         exp_wr[$];
    rd_t         exp_rd[$];
    logic [11:0] bus_log[$];
    logic [11:0] wr_addr = '0, last_wr_addr = '0;
    int          rd_count = 0, wr_beats = 0, run = 0;
    bit          chk_en = 0;
    logic        p_cs = 0, p_cswe = 0, p_rd = 0, p_hold = 0, p_last = 0;
    logic [31:0] p_data = '0;
    wr_t         we_e;
    rd_t         re_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle checker against the transaction model
    always @(negedge clk) begin
        if (!chk_en) begin
            p_cs = 0; p_cswe = 0; p_rd = 0; p_hold = 0; run = 0;
        end else begin
            check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            check("cs_while_resp", 32'(api_cs & rd_valid), 32'd0);
            check("wr_ready_legal", 32'(wr_ready & (api_cs | !busy)), 32'd0);
            if (api_cs && !p_cs) bus_log.push_back(api_addr);
            if (api_cs && api_we) begin
                check("wr_pulse_len", 32'(p_cswe), 32'd0);
                if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    we_e = exp_wr.pop_front();
                    check("wr_addr", 32'(api_addr), 32'(we_e.a));
                    check("wr_data", api_wdata, we_e.d);
                end
                wr_beats++;
                last_wr_addr = api_addr;
            end
            if (api_cs && !api_we) run++;
            else begin
                if (p_rd) check("rd_cs_len", 32'(run), 32'(RW + 1));
                run = 0;
            end
            if (p_hold) begin
                check("rd_hold_valid", 32'(rd_valid), 32'd1);
                check("rd_hold_data", rd_data, p_data);
                check("rd_hold_last", 32'(rd_last), 32'(p_last));
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else begin
                    re_e = exp_rd.pop_front();
                    check("rd_data", rd_data, re_e.d);
                    check("rd_last", 32'(rd_last), 32'(re_e.l));
                end
                rd_count++;
            end
            p_cs = api_cs; p_cswe = api_cs & api_we; p_rd = api_cs & !api_we;
            p_hold = rd_valid & !rd_ready; p_data = rd_data; p_last = rd_last;
        end
    end

    task automatic do_cmd(input logic we, input logic [11:0] a, input logic [7:0] len);
        bit ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_len = len;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        check("cmd_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) begin
            if (we) wr_addr = a;
            else for (int i = 0; i <= int'(len); i++) begin
                logic [11:0] ba;
                ba = a + 12'(i);
                exp_rd.push_back('{d: {20'h0, ba} ^ 32'hA5A5A5A5, l: i == int'(len)});
            end
        end
        #1 cmd_valid = 0;
    endtask

    task automatic wr_beat(input logic [31:0] d, input int gap);
        bit ok = 0;
        repeat (gap) @(posedge clk);
        #1 wr_valid = 1; wr_data = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_ready) begin ok = 1; break; end
        end
        check("wr_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) begin
            exp_wr.push_back('{a: wr_addr, d: d});
            wr_addr = wr_addr + 12'd1;
        end
        #1 wr_valid = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready && exp_rd.size() == 0 && exp_wr.size() == 0) begin ok = 1; break; end
        end
        check("burst_done", 32'(ok), 32'd1);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(api_cs), 32'd0);
        check("rst_we", 32'(api_we), 32'd0);
        check("rst_addr", 32'(api_addr), 32'd0);
        check("rst_wdata", api_wdata, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        #1 areset_n = 1;
        chk_en = 1;

        // Single write
        do_cmd(1'b1, 12'h010, 8'd0);
        wr_beat(32'hDEADBEEF, 0);
        @(negedge clk);
        check("sw_cs", 32'(api_cs), 32'd1);
        check("sw_we", 32'(api_we), 32'd1);
        check("sw_addr", 32'(api_addr), 32'h010);
        check("sw_data", api_wdata, 32'hDEADBEEF);
        check("sw_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("sw_cs_off", 32'(api_cs), 32'd0);
        check("sw_ready_back", 32'(cmd_ready), 32'd1);
        check("sw_data_held", api_wdata, 32'hDEADBEEF);
        wait_idle();

        // Read burst 0x020..0x023 with exact first-beat timing
        base = rd_count;
        do_cmd(1'b0, 12'h020, 8'd3);
        @(negedge clk);
        check("rb_cs_n1", 32'(api_cs), 32'd1);
        check("rb_busy_n1", 32'(busy), 32'd1);
        check("rb_addr_n1", 32'(api_addr), 32'h020);
        @(negedge clk);
        check("rb_cs_n2", 32'(api_cs), 32'd1);
        check("rb_we_n2", 32'(api_we), 32'd0);
        @(negedge clk);
        check("rb_cs_n3", 32'(api_cs), 32'd0);
        check("rb_valid_n3", 32'(rd_valid), 32'd1);
        check("rb_data_n3", rd_data, 32'hA5A5A585);
        check("rb_last_n3", 32'(rd_last), 32'd0);
        wait_idle();
        check("rb_count", 32'(rd_count - base), 32'd4);

        // Address wrap
        bus_log.delete();
        do_cmd(1'b0, 12'hFFE, 8'd2);
        wait_idle();
        check("wrap_n", 32'(bus_log.size()), 32'd3);
        if (bus_log.size() >= 3) begin
            check("wrap_a0", 32'(bus_log[0]), 32'hFFE);
            check("wrap_a1", 32'(bus_log[1]), 32'hFFF);
            check("wrap_a2", 32'(bus_log[2]), 32'h000);
        end

        // Response backpressure
        base = rd_count;
        do_cmd(1'b0, 12'h100, 8'd3);
        for (int i = 0; i < 200 && rd_count < base + 1; i++) @(negedge clk);
        @(posedge clk); #1 rd_ready = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_no_accept", 32'(rd_count - base), 32'd1);
        check("bp_pending", 32'(rd_valid), 32'd1);
        check("bp_data", rd_data, 32'hA5A5A4A4);
        check("bp_cs_low", 32'(api_cs), 32'd0);
        @(posedge clk); #1 rd_ready = 1;
        wait_idle();
        check("bp_count", 32'(rd_count - base), 32'd4);

        // Write-data gaps
        do_cmd(1'b1, 12'h200, 8'd2);
        wr_beat(32'h11110000, 5);
        wr_beat(32'h22220000, 5);
        wr_beat(32'h33330000, 5);
        wait_idle();

        // Reset during beat 2 of a 4-beat read
        base = rd_count;
        do_cmd(1'b0, 12'h300, 8'd3);
        for (int i = 0; i < 200 && rd_count < base + 1; i++) @(negedge clk);
        for (int i = 0; i < 20 && !api_cs; i++) @(negedge clk);
        check("mr_in_hold", 32'(api_cs & !api_we), 32'd1);
        chk_en = 0;
        #2 areset_n = 0;
        #1;
        check("mr_cs_async", 32'(api_cs), 32'd0);
        check("mr_we", 32'(api_we), 32'd0);
        check("mr_addr", 32'(api_addr), 32'd0);
        check("mr_valid", 32'(rd_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_ready", 32'(cmd_ready), 32'd1);
        exp_rd.delete();
        @(negedge clk); #1 areset_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mr_no_resp", 32'(rd_valid), 32'd0);
            check("mr_idle", 32'(cmd_ready), 32'd1);
            check("mr_no_cs", 32'(api_cs), 32'd0);
        end
        chk_en = 1;

        // Maximum burst length
        wr_beats = 0;
        do_cmd(1'b1, 12'h080, 8'd255);
        for (int i = 0; i < 256; i++) wr_beat(32'hF0000000 | 32'(i), 0);
        wait_idle();
        check("max_beats", 32'(wr_beats), 32'd256);
        check("max_last_addr", 32'(last_wr_addr), 32'h17F);
        check("max_idle", 32'(cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/nts_api_initiator.md
# nts_api_initiator

Bus initiator for the 12-bit-address / 32-bit-data NTS external API bus. It turns host commands on a valid/ready command stream into single or burst read/write cycles on `o_api_*`. Write data arrives on its own valid/ready stream, and read data returns on a valid/ready response stream. It sits between a host-side bridge (UART/SPI/PCIe shim) and the NTS address decoder that fans the bus out to the engine, clock, cookie, keymem and debug register sets.

## Interface
- `READ_WAIT`, default 1: extra cycles `o_api_cs` is held on a read before `i_api_read_data` is sampled (0..15).
- `i_clk`  in  1  single clock; all logic rising-edge.
- `i_areset_n`  in  1  asynchronous, active-low reset.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  command accepted when high with valid.
- `i_cmd_we`  in  1  1 = write burst, 0 = read burst.
- `i_cmd_address`  in  12  first word address.
- `i_cmd_length`  in  8  beats minus one (0 = 1 beat, 255 = 256 beats).
- `i_wr_valid` / `o_wr_ready`  in/out  1  write-data handshake.
- `i_wr_data`  in  32  write beat data.
- `o_rd_valid` / `i_rd_ready`  out/in  1  read-response handshake.
- `o_rd_data`  out  32  read beat data.
- `o_rd_last`  out  1  final beat of read burst.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_api_cs`, `o_api_we`  out  1  bus strobes.
- `o_api_address`  out  12  bus address.
- `o_api_write_data`  out  32  bus write data.
- `i_api_read_data`  in  32  bus read data, valid while `o_api_cs` is high.

## Operation
- All `o_api_*`, `o_rd_*` and `o_busy` outputs are registered.
- Reset values of those registered outputs: all 0. The FSM resets to IDLE.
- `o_cmd_ready` = (state == IDLE), so it is 1 from the first cycle after reset.
- `o_wr_ready` = (state == WR_WAIT).
- States: IDLE, WR_WAIT, WR_BEAT, RD_HOLD, RD_RESP.
- Internal registers: 12-bit address `addr`, 8-bit beat counter `remaining`, 4-bit hold counter.

IDLE
- On `i_cmd_valid`: latch address and length.
- If `i_cmd_we`: go to WR_WAIT.
- Else: go to RD_HOLD, asserting `cs`=1 and `we`=0 on the next cycle.

WR_WAIT
- Holds `cs`=0.
- On `i_wr_valid`: load `o_api_write_data`, assert `cs`=1 and `we`=1, go to WR_BEAT.

WR_BEAT
- `cs` is high for exactly this cycle.
- Then deassert `cs`/`we`.
- If `remaining`==0: go to IDLE.
- Else: `addr`+1, `remaining`−1, go to WR_WAIT.

RD_HOLD
- `cs`=1, `we`=0 for READ_WAIT+1 cycles.
- On the edge ending the last cycle: capture `i_api_read_data` into `o_rd_data`, set `o_rd_valid` and `o_rd_last` (= `remaining`==0), drop `cs`, go to RD_RESP.

RD_RESP
- Hold `o_rd_*` stable until `i_rd_ready`.
- On accept: clear `o_rd_valid`.
- If last beat: go to IDLE.
- Else: `addr`+1, `remaining`−1, re-enter RD_HOLD with `cs`=1 next cycle.

Rules and boundary cases
- Address arithmetic is 12-bit modulo: 0xFFF+1 = 0x000. No error is flagged; the decoder handles unmapped space by returning 0.
- `o_api_write_data` is held after a write beat. `o_api_address` always shows `addr`, even while `cs`=0.
- Write-data stall: WR_WAIT waits indefinitely with `cs` low. Write beats have no timeout.
- Stray write data in IDLE or during a read is not accepted (`o_wr_ready`=0).
- Response backpressure: RD_RESP waits indefinitely. No bus activity occurs while a response is pending (single response buffer).
- Reset mid-burst: `cs` and `we` drop asynchronously, the burst is discarded, and no response is produced.

## Timing
- Command accepted at edge N: `o_busy`=1 from N+1.
- Read beat, default READ_WAIT=1: `cs` high in cycles N+1 and N+2; `o_rd_valid` high from N+3.
- Read, zero-wait response: next beat `cs` rises 1 cycle after the response handshake.
- Write beat: data accepted at edge M; `cs`/`we` high for cycle M+1 only. Peak throughput is 1 beat per 2 cycles.
- End of burst: the last beat returns to IDLE, so `o_cmd_ready`=1 the cycle after the final WR_BEAT or the final read accept.
- Read throughput with zero-wait responses: READ_WAIT+2 cycles per beat.

## Structure
- `nts_api_pkg` holds:
  - the state enum;
  - API address/data width constants (12/32);
  - the decoder base/stop address constants shared with the decoder and the benches.
- No sub-module is needed: the FSM, counters and response register stay in one module of about 200 lines.

## Test plan
- Single write: cmd we=1, addr 0x010, len 0, wr_data 0xDEADBEEF → exactly one cycle of cs=we=1 at 0x010 with data 0xDEADBEEF; `o_cmd_ready` back to 1 two cycles after the write-data accept.
- Read burst, READ_WAIT=1: addr 0x020, len 3, always-ready response, memory model returns addr^0xA5A5A5A5 → 4 responses for 0x020..0x023; `o_rd_last` only on the 4th; each cs pulse lasts 2 cycles.
- Wrap: read addr 0xFFE, len 2 → bus addresses 0xFFE, 0xFFF, 0x000.
- Backpressure: `i_rd_ready` held 0 for 10 cycles mid-burst → `o_rd_data` stable, `cs`=0 throughout, no beat lost; `i_wr_valid` gaps of 5 cycles → `cs` stays low during each gap.
- Reset mid-burst: assert `i_areset_n`=0 during RD_HOLD of beat 2 of 4 → `cs` drops immediately, all outputs 0, IDLE with `o_cmd_ready`=1 after release, no response emitted.
- Max burst: write len 255 from 0x080 → 256 beats, last at 0x17F, `remaining` reaches 0 correctly.
